stump_mem_arbiter: RTL and testbench
====================================

// Module: stump_mem_arbiter
// PURPOSE
//  Shares the single-port Stump program/data memory between the Stump processor (priority
//  port) and a debug/loader port (program load, memory inspection while running).
//  Sits between Stump's memory interface and the memory array; the CPU always wins a
//  clash, and a starvation counter forces a one-access CPU freeze (cpu_hold) when debug
//  has waited too long. Also flags the halt convention (CPU write to HALT_ADDR).
// PARAMETERS
//  ADDR_W     16       address width
//  DATA_W     16       data width
//  MAX_WAIT   8        cycles a pending debug request may be refused before forcing hold (>=1)
//  HALT_ADDR  16'hFFFF CPU write address that sets halted
// PORTS
//  clk        in   1       system clock, all state on posedge
//  rst        in   1       asynchronous, active-high reset
//  cpu_addr   in   ADDR_W  Stump address
//  cpu_wdata  in   DATA_W  Stump data_out
//  cpu_wen    in   1       Stump mem_wen
//  cpu_ren    in   1       Stump mem_ren
//  cpu_rdata  out  DATA_W  to Stump data_in (mem_rdata passthrough)
//  cpu_hold   out  1       registered; freezes Stump (clock enable) while debug is forced
//  dbg_req    in   1       debug request; held high until dbg_ack
//  dbg_we     in   1       1 = write, 0 = read; stable while dbg_req
//  dbg_addr   in   ADDR_W  debug address; stable while dbg_req
//  dbg_wdata  in   DATA_W  debug write data; stable while dbg_req
//  dbg_ack    out  1       registered one-cycle completion pulse
//  dbg_rdata  out  DATA_W  read data, valid in the dbg_ack cycle, held until next ack
//  mem_addr   out  ADDR_W  to memory
//  mem_wdata  out  DATA_W  to memory
//  mem_wen    out  1       to memory (memory commits on negedge)
//  mem_ren    out  1       to memory (combinational read within cycle)
//  mem_rdata  in   DATA_W  from memory
//  halted     out  1       sticky: CPU wrote HALT_ADDR
// BEHAVIOUR
//  Reset (async): state=IDLE, wait_cnt=0, cpu_hold=0, dbg_ack=0, dbg_rdata=0, halted=0.
//  States: IDLE, FORCE, ACK.  Memory mux is combinational on state and inputs:
//   cpu_act = (cpu_ren|cpu_wen) & ~cpu_hold.
//   IDLE: cpu_act -> CPU owns memory; else dbg_req -> debug owns memory (grant);
//         else mem_wen=mem_ren=0, mem_addr/mem_wdata = CPU values.
//   FORCE: debug owns memory unconditionally; cpu_hold=1 throughout FORCE.
//   ACK: CPU-only routing; dbg_req ignored (no double grant).
//  Debug ownership: mem_addr=dbg_addr, mem_wdata=dbg_wdata, mem_wen=dbg_we, mem_ren=~dbg_we.
//  Transitions (posedge):
//   IDLE & grant -> ACK; dbg_rdata<=mem_rdata if read; dbg_ack<=1; wait_cnt<=0.
//   IDLE & dbg_req & cpu_act: wait_cnt+1; if wait_cnt==MAX_WAIT-1 -> FORCE, cpu_hold<=1.
//   FORCE -> ACK; capture as grant; cpu_hold<=0; wait_cnt<=0.
//   ACK -> IDLE; dbg_ack<=0.  Latency: grant in cycle N, dbg_ack in N+1.
//  dbg_req dropped while waiting: wait_cnt<=0, stay IDLE (request withdrawn, no ack).
//  Hold is only asserted from FORCE; CPU is frozen exactly one cycle per forced access.
//  halted <= 1 on posedge where CPU owns memory, cpu_wen=1, cpu_addr==HALT_ADDR;
//   the write is still forwarded to memory. Debug writes to HALT_ADDR do not set halted.
//  cpu_rdata = mem_rdata always (CPU ignores it when not its cycle).
//  wait_cnt width clog2(MAX_WAIT)+1, saturates; never wraps.
//  Reset mid-access: any in-flight debug access is abandoned, no ack issued.
// STRUCTURE
//  Shared include stump_mem_defs.v: state encodings (IDLE/FORCE/ACK), HALT_ADDR default,
//  ADDR_W/DATA_W defaults. One sub-module natural: stump_wait_counter (clear, inc, at_limit).
//  FSM + mux + halt flag stay in stump_mem_arbiter.
// TESTING
//  1 Reset: rst=1 async mid-cycle -> all outputs 0, mem_wen=mem_ren=0 with CPU idle.
//  2 Idle-slot debug read: CPU idle, dbg_req read 16'h0010 (mem=16'hBEEF) -> mem_ren=1
//    addr 0010 same cycle, dbg_ack next cycle, dbg_rdata=16'hBEEF, cpu_hold never 1.
//  3 Clash: cpu_ren and dbg_req write 16'h0020:=16'h1234 same cycle -> CPU gets memory,
//    debug granted first CPU-idle cycle, memory[0020]=1234 after ack.
//  4 Starvation: CPU accesses every cycle, MAX_WAIT=8 -> cpu_hold=1 for one cycle after 8
//    refused cycles, debug access in that cycle, dbg_ack next, CPU resumes.
//  5 Halt: CPU writes 16'h0000 to 16'hFFFF -> halted=1 next edge, stays 1 until rst;
//    debug write to FFFF leaves halted=0.
//  6 Withdraw/reset mid-op: dbg_req dropped after 3 refused cycles -> no ack, wait_cnt=0;
//    rst asserted in FORCE -> cpu_hold=0 immediately, no dbg_ack.

Source files
------------

// File: rtl/stump_mem_arbiter_pkg.sv
// Shared types and defaults for the Stump memory arbiter: FSM encoding, bus widths,
// starvation limit and the halt address convention.
package stump_mem_arbiter_pkg;

   localparam int unsigned DefAddrW   = 16;
   localparam int unsigned DefDataW   = 16;
   localparam int unsigned DefMaxWait = 8;
   localparam logic [15:0] DefHaltAddr = 16'hFFFF;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StForce = 2'd1,
      StAck   = 2'd2
   } arb_state_e;

   // Counter wide enough to hold MAX_WAIT itself, so the limit compare never wraps.
   function automatic int unsigned wait_cnt_width(input int unsigned max_wait);
      return $clog2(max_wait) + 1;
   endfunction

endpackage

// File: rtl/stump_wait_counter.sv
// Counts cycles a pending debug request has been refused; flags the cycle in which one
// more refusal reaches the starvation limit.
module stump_wait_counter
   import stump_mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_WAIT = DefMaxWait
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic at_limit
);

   localparam int unsigned CntW = wait_cnt_width(MAX_WAIT);
   localparam logic [CntW-1:0] Limit = CntW'(MAX_WAIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit = (cnt_q == Limit);

endmodule

// File: rtl/stump_mem_arbiter.sv
// Shares the single-port Stump memory between the CPU (priority) and a debug/loader port,
// forcing a one-cycle CPU freeze when debug starves, and flagging CPU writes to HALT_ADDR.
module stump_mem_arbiter
   import stump_mem_arbiter_pkg::*;
#(
   parameter int unsigned       ADDR_W    = DefAddrW,
   parameter int unsigned       DATA_W    = DefDataW,
   parameter int unsigned       MAX_WAIT  = DefMaxWait,
   parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(DefHaltAddr)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_wen,
   input  logic              cpu_ren,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_hold,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wen,
   output logic              mem_ren,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              halted
);

   arb_state_e state;

   logic cpu_act;
   logic cpu_own;
   logic grant;
   logic dbg_own;
   logic wait_clear;
   logic wait_inc;
   logic at_limit;

   // A held CPU is frozen, so its strobes do not count as a request.
   assign cpu_act = (cpu_ren | cpu_wen) & ~cpu_hold;
   assign grant   = (state == StIdle) & ~cpu_act & dbg_req;
   assign dbg_own = grant | (state == StForce);
   assign cpu_own = cpu_act & (state != StForce);

   assign cpu_rdata = mem_rdata;

   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = 1'b0;
      mem_ren   = 1'b0;
      if (dbg_own) begin
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
         mem_wen   = dbg_we;
         mem_ren   = ~dbg_we;
      end else if (cpu_own) begin
         mem_wen = cpu_wen;
         mem_ren = cpu_ren;
      end
   end

   assign wait_inc   = (state == StIdle) & dbg_req & cpu_act;
   assign wait_clear = grant | (state == StForce) | ((state == StIdle) & ~dbg_req);

   stump_wait_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_counter (
      .clk      (clk),
      .rst      (rst),
      .clear    (wait_clear),
      .inc      (wait_inc),
      .at_limit (at_limit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         cpu_hold  <= 1'b0;
         dbg_ack   <= 1'b0;
         dbg_rdata <= '0;
         halted    <= 1'b0;
      end else begin
         // The halting write itself still reaches memory through the mux above.
         if (cpu_own && cpu_wen && (cpu_addr == HALT_ADDR)) begin
            halted <= 1'b1;
         end
         if (dbg_own && !dbg_we) begin
            dbg_rdata <= mem_rdata;
         end
         unique case (state)
            StIdle: begin
               if (grant) begin
                  state   <= StAck;
                  dbg_ack <= 1'b1;
               end else if (wait_inc && at_limit) begin
                  state    <= StForce;
                  cpu_hold <= 1'b1;
               end
            end
            StForce: begin
               state    <= StAck;
               cpu_hold <= 1'b0;
               dbg_ack  <= 1'b1;
            end
            StAck: begin
               state   <= StIdle;
               dbg_ack <= 1'b0;
            end
            default: begin
               state    <= StIdle;
               cpu_hold <= 1'b0;
               dbg_ack  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stump_mem_arbiter.sv
// Randomized bench for stump_mem_arbiter: a transaction-level model of the sharing rules
// predicts routing, acks, holds, read data, halt flag and final memory contents.
module tb_stump_mem_arbiter;

   localparam int          MAX_WAIT = 8;
   localparam logic [15:0] HALT     = 16'hFFFF;

   logic        clk;
   logic        rst;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_wen, cpu_ren, cpu_hold;
   logic        dbg_req, dbg_we, dbg_ack;
   logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_wen, mem_ren;
   logic        halted;

   stump_mem_arbiter #(
      .ADDR_W    (16),
      .DATA_W    (16),
      .MAX_WAIT  (MAX_WAIT),
      .HALT_ADDR (HALT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_wen   (cpu_wen),
      .cpu_ren   (cpu_ren),
      .cpu_rdata (cpu_rdata),
      .cpu_hold  (cpu_hold),
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_ack   (dbg_ack),
      .dbg_rdata (dbg_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wen   (mem_wen),
      .mem_ren   (mem_ren),
      .mem_rdata (mem_rdata),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical memory seen by the DUT, and the model's idea of what it should hold.
   logic [15:0] env_mem [65536];
   logic [15:0] ref_mem [65536];

   assign mem_rdata = env_mem[mem_addr];
   always @(negedge clk) if (mem_wen) env_mem[mem_addr] <= mem_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model state: who is frozen, whether an ack is due, how long debug has been refused.
   bit          m_hold, m_ack, m_halted;
   int          m_refused;
   logic [15:0] m_rdata;

   function automatic bit cpu_wants();
      return (cpu_ren || cpu_wen) && !m_hold;
   endfunction

   function automatic bit dbg_served();
      return m_hold || (!m_ack && dbg_req && !cpu_wants());
   endfunction

   function automatic logic [15:0] pick_addr(input bit allow_halt);
      int i;
      i = allow_halt ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 6));
      case (i)
         0: return 16'h0010;
         1: return 16'h0020;
         2: return 16'h0030;
         3: return 16'h0100;
         4: return 16'h0101;
         5: return 16'h0200;
         6: return 16'h1234;
         default: return HALT;
      endcase
   endfunction

   task automatic model_reset();
      m_hold    = 0;
      m_ack     = 0;
      m_halted  = 0;
      m_refused = 0;
      m_rdata   = '0;
   endtask

   task automatic model_edge();
      bit cw, sv;
      cw = cpu_wants();
      sv = dbg_served();
      if (cw && cpu_wen) begin
         ref_mem[cpu_addr] = cpu_wdata;
         if (cpu_addr == HALT) m_halted = 1;
      end
      if (sv) begin
         if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
         else        m_rdata = ref_mem[dbg_addr];
         m_ack     = 1;
         m_hold    = 0;
         m_refused = 0;
      end else if (m_ack) begin
         m_ack = 0;
      end else if (dbg_req && cw) begin
         m_refused++;
         if (m_refused == MAX_WAIT) m_hold = 1;
      end else begin
         m_refused = 0;
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
      model_edge();
      check("cpu_hold",  32'(cpu_hold),  32'(m_hold));
      check("dbg_ack",   32'(dbg_ack),   32'(m_ack));
      check("dbg_rdata", 32'(dbg_rdata), 32'(m_rdata));
      check("halted",    32'(halted),    32'(m_halted));
      if (m_ack) dbg_req = 1'b0;
   endtask

   task automatic comb_step();
      logic [15:0] ea, ed;
      bit          ew, er;
      #1;
      if (dbg_served()) begin
         ea = dbg_addr; ed = dbg_wdata; ew = dbg_we; er = !dbg_we;
      end else begin
         ea = cpu_addr; ed = cpu_wdata;
         ew = cpu_wants() && cpu_wen;
         er = cpu_wants() && cpu_ren;
      end
      check("mem_addr",  32'(mem_addr),  32'(ea));
      check("mem_wdata", 32'(mem_wdata), 32'(ed));
      check("mem_wen",   32'(mem_wen),   32'(ew));
      check("mem_ren",   32'(mem_ren),   32'(er));
      check("cpu_rdata", 32'(cpu_rdata), 32'(env_mem[ea]));
   endtask

   task automatic set_cpu(input int op, input logic [15:0] a, input logic [15:0] d);
      cpu_ren   = (op == 1);
      cpu_wen   = (op == 2);
      cpu_addr  = a;
      cpu_wdata = d;
   endtask

   task automatic dbg_start(input bit we, input logic [15:0] a, input logic [15:0] d);
      dbg_req   = 1'b1;
      dbg_we    = we;
      dbg_addr  = a;
      dbg_wdata = d;
   endtask

   task automatic do_reset();
      set_cpu(0, 16'h0000, 16'h0000);
      dbg_req = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rst_cpu_hold",  32'(cpu_hold),  32'd0);
      check("rst_dbg_ack",   32'(dbg_ack),   32'd0);
      check("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
      check("rst_halted",    32'(halted),    32'd0);
      check("rst_mem_wen",   32'(mem_wen),   32'd0);
      check("rst_mem_ren",   32'(mem_ren),   32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // CPU reads every cycle until the DUT freezes it; returns how many cycles debug was refused.
   task automatic count_refused(output int n);
      n = 0;
      for (int k = 0; k < 4 * MAX_WAIT; k++) begin
         set_cpu(1, pick_addr(0), 16'h0000);
         comb_step();
         n++;
         edge_step();
         if (cpu_hold) break;
      end
   endtask

   initial begin
      int n, busy, op;
      rst = 1'b0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      set_cpu(0, 16'h0000, 16'h0000);
      for (int i = 0; i < 65536; i++) begin
         env_mem[i] = '0;
         ref_mem[i] = '0;
      end
      for (int i = 0; i < 8; i++) begin
         logic [15:0] a, v;
         a = pick_addr(1);
         v = 16'($urandom);
         env_mem[a] = v;
         ref_mem[a] = v;
      end
      env_mem[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
      env_mem[16'h0100] = 16'h5A5A; ref_mem[16'h0100] = 16'h5A5A;

      do_reset();

      // Debug read in an idle CPU slot.
      dbg_start(0, 16'h0010, 16'h0000);
      comb_step();
      check("idle_rd_ren",  32'(mem_ren),  32'd1);
      check("idle_rd_addr", 32'(mem_addr), 32'h0010);
      edge_step();
      check("idle_rd_ack",   32'(dbg_ack),   32'd1);
      check("idle_rd_data",  32'(dbg_rdata), 32'hBEEF);
      check("idle_rd_nohold", 32'(cpu_hold), 32'd0);
      comb_step();
      edge_step();

      // Clash: CPU wins, debug write lands in the next CPU-idle cycle.
      set_cpu(1, 16'h0030, 16'h0000);
      dbg_start(1, 16'h0020, 16'h1234);
      comb_step();
      check("clash_cpu_addr", 32'(mem_addr), 32'h0030);
      edge_step();
      set_cpu(0, 16'h0030, 16'h0000);
      comb_step();
      check("clash_dbg_wen",  32'(mem_wen),  32'd1);
      check("clash_dbg_addr", 32'(mem_addr), 32'h0020);
      edge_step();
      check("clash_ack", 32'(dbg_ack), 32'd1);
      comb_step();
      edge_step();
      check("clash_mem", 32'(env_mem[16'h0020]), 32'h1234);

      // Starvation: a permanently busy CPU gets frozen after MAX_WAIT refusals.
      dbg_start(0, 16'h0100, 16'h0000);
      count_refused(n);
      check("starve_refused", 32'(n), 32'(MAX_WAIT));
      set_cpu(1, 16'h0030, 16'h0000);
      comb_step();
      check("starve_dbg_addr", 32'(mem_addr), 32'h0100);
      check("starve_dbg_ren",  32'(mem_ren),  32'd1);
      edge_step();
      check("starve_ack",    32'(dbg_ack),   32'd1);
      check("starve_unhold", 32'(cpu_hold),  32'd0);
      check("starve_data",   32'(dbg_rdata), 32'h5A5A);
      comb_step();
      check("starve_cpu_back", 32'(mem_addr), 32'h0030);
      edge_step();

      // Halt convention: CPU write sets the sticky flag, debug write does not.
      set_cpu(2, HALT, 16'h0000);
      comb_step();
      edge_step();
      check("halt_set", 32'(halted), 32'd1);
      set_cpu(0, 16'h0000, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         comb_step();
         edge_step();
      end
      check("halt_sticky", 32'(halted), 32'd1);
      do_reset();
      dbg_start(1, HALT, 16'h0000);
      comb_step();
      edge_step();
      check("dbg_halt_ack", 32'(dbg_ack), 32'd1);
      comb_step();
      edge_step();
      check("dbg_halt_noflag", 32'(halted), 32'd0);

      // Withdrawn request: no ack, and the refusal count restarts from zero.
      dbg_start(0, 16'h0101, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         set_cpu(1, 16'h0030, 16'h0000);
         comb_step();
         edge_step();
      end
      dbg_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         comb_step();
         edge_step();
         check("withdraw_noack", 32'(dbg_ack), 32'd0);
      end
      dbg_start(0, 16'h0101, 16'h0000);
      count_refused(n);
      check("withdraw_restart", 32'(n), 32'(MAX_WAIT));
      // Reset while frozen: hold drops at once and the forced access is abandoned.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         comb_step();
         edge_step();
         check("force_rst_noack", 32'(dbg_ack), 32'd0);
      end

      // Randomized traffic with varying CPU load, withdrawals and occasional resets.
      busy = 5;
      for (int c = 0; c < 3000; c++) begin
         if (c % 64 == 0) busy = int'($urandom_range(0, 10));
         if ($urandom_range(0, 599) == 0) do_reset();
         if (!dbg_req && ($urandom_range(0, 2) == 0)) begin
            dbg_start(1'($urandom_range(0, 1)), pick_addr(1), 16'($urandom));
         end else if (dbg_req && ($urandom_range(0, 49) == 0)) begin
            dbg_req = 1'b0;
         end
         op = (int'($urandom_range(1, 10)) <= busy) ? int'($urandom_range(1, 2)) : 0;
         set_cpu(op, ($urandom_range(0, 31) == 0) ? HALT : pick_addr(0), 16'($urandom));
         comb_step();
         edge_step();
      end

      set_cpu(0, 16'h0000, 16'h0000);
      dbg_req = 1'b0;
      comb_step();
      edge_step();
      #5;
      for (int i = 0; i < 8; i++) begin
         logic [15:0] a;
         case (i)
            0: a = 16'h0010;
            1: a = 16'h0020;
            2: a = 16'h0030;
            3: a = 16'h0100;
            4: a = 16'h0101;
            5: a = 16'h0200;
            6: a = 16'h1234;
            default: a = HALT;
         endcase
         check("mem_final", 32'(env_mem[a]), 32'(ref_mem[a]));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
